// File: rtl/sram_bulk_sequencer_if.sv
// Host-side bundle for the SRAM bulk sequencer: the command handshake,
// the abort request, the write-byte handshake, the read-FIFO drain port
// and the busy flag.
//   slave  : the sequencer (takes commands, produces read bytes)
//   master : the host register decoder
interface sram_bulk_sequencer_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_count;
  logic              abort;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_count, abort,
    input  wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_count, abort,
    output wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/sram_bulk_sequencer.sv
// Burst access engine for a 62256-class SRAM on the ZIF socket. Takes a
// read/write burst command from the host, auto-increments the address,
// generates /CE, /OE, /WE with a programmable strobe width and buffers read
// bytes in a small FIFO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   host (slave)      command / abort / write-byte / read-FIFO / busy bundle
//   dut_addr          SRAM address pins
//   dut_dout          data driven onto DQ when dut_drive = 1
//   dut_drive         DQ output enable (1 = FPGA drives)
//   dut_din           DQ pins, sampled directly
//   dut_ce_n/oe_n/we_n active-low strobes
// wr_ready is a registered one-cycle acknowledge: it is high in the cycle
// after the byte was taken (first strobe cycle), telling the host to advance.
module sram_bulk_sequencer #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned RD_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_bulk_sequencer_if.slave host,
  output logic [ADDR_W-1:0]    dut_addr,
  output logic [DATA_W-1:0]    dut_dout,
  output logic                 dut_drive,
  input  logic [DATA_W-1:0]    dut_din,
  output logic                 dut_ce_n,
  output logic                 dut_oe_n,
  output logic                 dut_we_n
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned PTR_W  = $clog2(RD_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_RECOVER} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                drive_q, drive_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                write_q, write_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                wr_ready_q, wr_ready_d;

  logic [DATA_W-1:0]   mem_q [RD_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                push, pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, strobe and FIFO control
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    drive_d     = drive_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    write_d     = write_q;
    remain_d    = remain_q;
    strb_d      = strb_q;
    wr_ready_d  = 1'b0;
    push        = 1'b0;
    pop         = host.rd_ready && (fcnt_q != '0);

    if (state_q != ST_IDLE && host.abort) begin
      // Abort drops the byte in flight; FIFO contents survive
      state_d = ST_IDLE;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      drive_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (host.cmd_valid && cmd_ready_q && host.cmd_count != '0) begin
            addr_d   = host.cmd_addr;
            remain_d = host.cmd_count;
            write_d  = host.cmd_write;
            ce_n_d   = 1'b0;
            state_d  = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (write_q) begin
            if (host.wr_valid) begin
              dout_d     = host.wr_data;
              drive_d    = 1'b1;
              wr_ready_d = 1'b1;
              we_n_d     = 1'b0;
              strb_d     = STRB_W'(STROBE_CYC - 1);
              state_d    = ST_STROBE;
            end
          end else if (fcnt_q < FCNT_W'(RD_DEPTH)) begin
            // Registered count only, so a full FIFO can never be pushed
            oe_n_d  = 1'b0;
            strb_d  = STRB_W'(STROBE_CYC - 1);
            state_d = ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (strb_q == '0) begin
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            push    = !write_q;
            state_d = ST_RECOVER;
          end else begin
            strb_d = strb_q - STRB_W'(1);
          end
        end
        ST_RECOVER: begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - CNT_W'(1);
          drive_d  = 1'b0;
          if (remain_q == CNT_W'(1)) begin
            ce_n_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SETUP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);

    wptr_d     = wptr_q + PTR_W'(push);
    rptr_d     = rptr_q + PTR_W'(pop);
    fcnt_d     = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
    rd_valid_d = (fcnt_d != '0);
    // Head after this edge: the incoming byte if the FIFO would otherwise be empty
    rd_data_d  = (push && (wptr_q == rptr_d)) ? dut_din : mem_q[rptr_d];
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      dout_q      <= '0;
      drive_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      write_q     <= 1'b0;
      remain_q    <= '0;
      strb_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      drive_q     <= drive_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      write_q     <= write_d;
      remain_q    <= remain_d;
      strb_q      <= strb_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      wr_ready_q  <= wr_ready_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Read FIFO storage (no reset needed, guarded by the count)
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dut_din;
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.busy      = busy_q;
  assign host.wr_ready  = wr_ready_q;
  assign host.rd_valid  = rd_valid_q;
  assign host.rd_data   = rd_data_q;
  assign dut_addr       = addr_q;
  assign dut_dout       = dout_q;
  assign dut_drive      = drive_q;
  assign dut_ce_n       = ce_n_q;
  assign dut_oe_n       = oe_n_q;
  assign dut_we_n       = we_n_q;

endmodule
